// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader for the 16x8 program memory.
// Ports: clk, rst_n, rx_data/rx_valid/rx_ready (byte input handshake),
//   prog_we/prog_addr/prog_wdata (memory write port),
//   cpu_hold, load_done, load_error (status to top level).
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CYCLES = 1200000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [7:0]        prog_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CKSUM,
        EVAL
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              match_q, match_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic              to_hit;

    assign rx_ready   = (state_q != EVAL);
    assign accept     = rx_valid && rx_ready;
    assign to_hit     = (to_q == TO_LAST);
    assign prog_we    = we_q;
    assign prog_addr  = addr_q;
    assign prog_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        to_d    = to_q;
        match_d = match_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d = DATA;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    to_d    = '0;
                end
            end
            DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = rx_data;
                    sum_d   = sum_q + rx_data;
                    cnt_d   = cnt_q + 1'b1;
                    to_d    = '0;
                    if (cnt_q == {ADDR_W{1'b1}}) begin
                        state_d = CKSUM;
                    end
                end else if (to_hit) begin
                    // Sender stalled: abandon frame, keep CPU held.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    to_d    = '0;
                    cnt_d   = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            CKSUM: begin
                if (accept) begin
                    state_d = EVAL;
                    match_d = ((sum_q + rx_data) == 8'h00);
                    to_d    = '0;
                end else if (to_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    to_d    = '0;
                    cnt_d   = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            EVAL: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (match_q) begin
                    done_d = 1'b1;
                    hold_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            match_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
            match_q <= match_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader.
// Writes are checked by a monitor against an expected-write queue.
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    prog_loader #(
        .SYNC_BYTE     (8'hA5),
        .ADDR_W        (4),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_error(load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && prog_we) begin
            logic [11:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         prog_addr, prog_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({prog_addr, prog_wdata} != e) begin
                    bad++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             prog_addr, prog_wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL rx_ready_wait: got 0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d[16], input logic [7:0] ck,
                         input int nbytes);
        send(8'hA5);
        check("hold_after_sync", int'(cpu_hold), 1);
        check("err_cleared", int'(load_error), 0);
        for (int i = 0; i < nbytes; i++) begin
            exp_q.push_back({4'(i), d[i]});
            send(d[i]);
        end
        if (nbytes == 16) send(ck);
        rx_valid = 1'b0;
    endtask

    task automatic eval_check(input bit good, input string tag);
        @(posedge clk);
        #1;
        if (good) begin
            check({tag, "_done"}, int'(load_done), 1);
            check({tag, "_hold"}, int'(cpu_hold), 0);
            check({tag, "_err"}, int'(load_error), 0);
            @(posedge clk);
            #1;
            check({tag, "_done_pulse"}, int'(load_done), 0);
        end else begin
            check({tag, "_done"}, int'(load_done), 0);
            check({tag, "_hold"}, int'(cpu_hold), 1);
            check({tag, "_err"}, int'(load_error), 1);
            @(posedge clk);
            #1;
            check({tag, "_done_late"}, int'(load_done), 0);
        end
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    logic [7:0] base[16];
    logic [7:0] syn[16];
    int w;

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            base[i] = 8'(i + 1);
            syn[i]  = 8'(i + 1);
        end
        syn[3] = 8'hA5;
        #12;
        check("rst_we", int'(prog_we), 0);
        check("rst_addr", int'(prog_addr), 0);
        check("rst_wdata", int'(prog_wdata), 0);
        check("rst_hold", int'(cpu_hold), 0);
        check("rst_done", int'(load_done), 0);
        check("rst_err", int'(load_error), 0);
        check("rst_ready", int'(rx_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        frame(base, 8'h78, 16);
        eval_check(1'b1, "good");

        frame(base, 8'h77, 16);
        eval_check(1'b0, "badck");
        idle(3);
        check("badck_err_sticky", int'(load_error), 1);
        frame(base, 8'h78, 16);
        eval_check(1'b1, "recover");

        send(8'h00);
        send(8'hFF);
        send(8'h3C);
        rx_valid = 1'b0;
        check("garbage_hold", int'(cpu_hold), 0);
        frame(base, 8'h78, 16);
        eval_check(1'b1, "garbage");

        frame(syn, 8'hD7, 16);
        eval_check(1'b1, "syncdata");

        frame(base, 8'h00, 5);
        idle(10);
        check("to_early", int'(load_error), 0);
        w = 0;
        while (!load_error && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("to_err", int'(load_error), 1);
        check("to_hold", int'(cpu_hold), 1);
        check("to_ready", int'(rx_ready), 1);
        send(8'h3C);
        rx_valid = 1'b0;
        idle(3);
        check("to_ignore_err", int'(load_error), 1);
        check("to_ignore_hold", int'(cpu_hold), 1);
        check("to_q_empty", exp_q.size(), 0);

        frame(base, 8'h00, 8);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_we", int'(prog_we), 0);
        check("arst_hold", int'(cpu_hold), 0);
        check("arst_err", int'(load_error), 0);
        check("arst_addr", int'(prog_addr), 0);
        check("arst_q_empty", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        frame(base, 8'h78, 16);
        eval_check(1'b1, "after_rst");

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
